// File: rtl/pt_arbiter.sv
// pt_arbiter: picks whichever crack core starts writing plaintext first,
// forwards that core's bytes (one cycle late) into the shared plaintext
// memory, then waits a bounded time for the winner's key. If both cores
// finish without a key, or the winner never produces one, the run fails.
module pt_arbiter #(
  parameter int AW      = 8,
  parameter int KW      = 24,
  parameter int KV_WAIT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          rdy,
  input  logic [AW-1:0] a_fpt_addr,
  input  logic [7:0]    a_fpt_wrdata,
  input  logic          a_fpt_wren,
  input  logic [KW-1:0] a_key,
  input  logic          a_key_valid,
  input  logic          a_rdy,
  input  logic [AW-1:0] b_fpt_addr,
  input  logic [7:0]    b_fpt_wrdata,
  input  logic          b_fpt_wren,
  input  logic [KW-1:0] b_key,
  input  logic          b_key_valid,
  input  logic          b_rdy,
  output logic [AW-1:0] pt_addr,
  output logic [7:0]    pt_wrdata,
  output logic          pt_wren,
  output logic [KW-1:0] key,
  output logic          key_valid,
  output logic          done,
  output logic [AW:0]   nbytes
);

  localparam int CW = $clog2(KV_WAIT + 1);
  localparam logic [AW:0] NMAX = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] KCNT_LAST = CW'(KV_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COPY_A,
    S_COPY_B,
    S_KWAIT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t          state_q;
  logic            rdy_q;
  logic [AW-1:0]   pt_addr_q;
  logic [7:0]      pt_wrdata_q;
  logic            pt_wren_q;
  logic [KW-1:0]   key_q;
  logic            key_valid_q;
  logic            done_q;
  logic [AW:0]     nbytes_q;
  logic            fail_a_q;
  logic            fail_b_q;
  logic            a_rdy_prev_q;
  logic            b_rdy_prev_q;
  logic            win_b_q;
  logic [CW-1:0]   kcnt_q;

  logic            fail_a_d;
  logic            fail_b_d;
  logic [AW:0]     nbytes_d;
  logic [KW-1:0]   win_key_d;
  logic            win_kv_d;

  // Core failure = ready rising while no key is reported; byte count saturates; winner key mux.
  always_comb begin
    fail_a_d  = fail_a_q | (a_rdy & ~a_rdy_prev_q & ~a_key_valid);
    fail_b_d  = fail_b_q | (b_rdy & ~b_rdy_prev_q & ~b_key_valid);
    nbytes_d  = (nbytes_q == NMAX) ? nbytes_q : nbytes_q + 1'b1;
    win_key_d = win_b_q ? b_key : a_key;
    win_kv_d  = win_b_q ? b_key_valid : a_key_valid;
  end

  // Arbitration FSM with all outputs registered; pt_wren defaults low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rdy_q        <= 1'b1;
      pt_addr_q    <= '0;
      pt_wrdata_q  <= '0;
      pt_wren_q    <= 1'b0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      nbytes_q     <= '0;
      fail_a_q     <= 1'b0;
      fail_b_q     <= 1'b0;
      a_rdy_prev_q <= 1'b0;
      b_rdy_prev_q <= 1'b0;
      win_b_q      <= 1'b0;
      kcnt_q       <= '0;
    end else begin
      a_rdy_prev_q <= a_rdy;
      b_rdy_prev_q <= b_rdy;
      pt_wren_q    <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (en) begin
            state_q     <= S_ARM;
            rdy_q       <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            nbytes_q    <= '0;
            fail_a_q    <= 1'b0;
            fail_b_q    <= 1'b0;
          end
        end

        S_ARM: begin
          // The selecting write is itself forwarded; A wins a same-edge tie.
          if (a_fpt_wren && !fail_a_q) begin
            state_q     <= S_COPY_A;
            win_b_q     <= 1'b0;
            pt_wren_q   <= 1'b1;
            pt_addr_q   <= a_fpt_addr;
            pt_wrdata_q <= a_fpt_wrdata;
            nbytes_q    <= nbytes_d;
          end else if (b_fpt_wren && !fail_b_q) begin
            state_q     <= S_COPY_B;
            win_b_q     <= 1'b1;
            pt_wren_q   <= 1'b1;
            pt_addr_q   <= b_fpt_addr;
            pt_wrdata_q <= b_fpt_wrdata;
            nbytes_q    <= nbytes_d;
          end else begin
            fail_a_q <= fail_a_d;
            fail_b_q <= fail_b_d;
            if (fail_a_d && fail_b_d) begin
              state_q <= S_FAIL;
              done_q  <= 1'b1;
              rdy_q   <= 1'b1;
            end
          end
        end

        S_COPY_A: begin
          if (a_fpt_wren) begin
            pt_wren_q   <= 1'b1;
            pt_addr_q   <= a_fpt_addr;
            pt_wrdata_q <= a_fpt_wrdata;
            nbytes_q    <= nbytes_d;
          end else begin
            state_q <= S_KWAIT;
            kcnt_q  <= '0;
          end
        end

        S_COPY_B: begin
          if (b_fpt_wren) begin
            pt_wren_q   <= 1'b1;
            pt_addr_q   <= b_fpt_addr;
            pt_wrdata_q <= b_fpt_wrdata;
            nbytes_q    <= nbytes_d;
          end else begin
            state_q <= S_KWAIT;
            kcnt_q  <= '0;
          end
        end

        S_KWAIT: begin
          // A stream that never yields a key within the window is treated as bogus.
          if (win_kv_d) begin
            state_q     <= S_DONE;
            key_q       <= win_key_d;
            key_valid_q <= 1'b1;
            done_q      <= 1'b1;
            rdy_q       <= 1'b1;
          end else if (kcnt_q == KCNT_LAST) begin
            state_q <= S_FAIL;
            done_q  <= 1'b1;
            rdy_q   <= 1'b1;
          end else begin
            kcnt_q <= kcnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign done      = done_q;
  assign nbytes    = nbytes_q;

endmodule
